writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register data and result width.
REQ-002 SHALL have parameter ADDR_W, default 32: PC width.
REQ-003 SHALL have parameter EXC_W, default 4: exception cause width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pipeline_in_valid  input  1  memory stage holds a valid instruction.
REQ-007 SHALL have port nop_instr_in  input  1  instruction is a NOP.
REQ-008 SHALL have port result_in  input  DATA_W  value to write back.
REQ-009 SHALL have port rd_addr_in  input  5  destination register.
REQ-010 SHALL have port PC_in  input  ADDR_W  PC of the instruction.
REQ-011 SHALL have port exception_in  input  EXC_W  exception cause.
REQ-012 SHALL have port exception_in_valid  input  1  exception present.
REQ-013 SHALL have port trap_ack  input  1  trap handler has consumed the trap.
REQ-014 SHALL have port rf_wr_enable  output  1  register-file write strobe.
REQ-015 SHALL have port rf_wr_addr  output  5  register-file write address.
REQ-016 SHALL have port rf_wr_data  output  DATA_W  register-file write data.
REQ-017 SHALL have port trap_valid  output  1  trap pending.
REQ-018 SHALL have port trap_cause  output  EXC_W  latched cause.
REQ-019 SHALL have port trap_pc  output  ADDR_W  latched faulting PC.
REQ-020 SHALL have port flush_out  output  1  one-cycle pipeline flush request.
REQ-021 SHALL have port stall_out  output  1  stall request to upstream stages.
REQ-022 SHALL have port instret  output  64  retired-instruction counter.

Function
REQ-023 SHALL implement states RUN, TRAP_FLUSH, TRAP_WAIT.
REQ-024 SHALL define "accept" as: state RUN and pipeline_in_valid=1 at a rising edge.
REQ-025 SHALL define "retire" as: accept, nop_instr_in=0, and exception_in_valid=0.
REQ-026 On retire with rd_addr_in!=0, SHALL drive rf_wr_enable=1 for exactly the following cycle, with rf_wr_addr/rf_wr_data equal to the sampled rd_addr_in/result_in (1-cycle latency).
REQ-027 SHALL never assert rf_wr_enable for rd_addr_in=0, for a NOP, for an excepting instruction, or outside RUN.
REQ-028 SHALL hold rf_wr_addr/rf_wr_data at their last values when rf_wr_enable=0.
REQ-029 SHALL increment instret by 1 on each retire, including retires with rd=0; it wraps from 2^64-1 to 0.
REQ-030 On accept with exception_in_valid=1, SHALL latch trap_cause=exception_in and trap_pc=PC_in, set trap_valid=1, and enter TRAP_FLUSH; the exception takes priority over the nop flag.
REQ-031 TRAP_FLUSH SHALL assert flush_out=1 for exactly one cycle, then go unconditionally to TRAP_WAIT; trap_ack is ignored in TRAP_FLUSH.
REQ-032 TRAP_WAIT SHALL hold trap_valid/trap_cause/trap_pc stable until trap_ack=1, then clear trap_valid and return to RUN at that edge.
REQ-033 stall_out SHALL be combinational: 1 whenever state != RUN; 0 in RUN.
REQ-034 Inputs SHALL be ignored (no write, no count, no new trap) while in TRAP_FLUSH or TRAP_WAIT.
REQ-035 An excepting instruction SHALL NOT write the register file and SHALL NOT increment instret.
REQ-036 Back-to-back retires SHALL produce back-to-back rf_wr_enable pulses with no bubble.

Reset
REQ-037 On reset=1, asynchronously and regardless of clk, SHALL go to RUN and clear rf_wr_enable, rf_wr_addr, rf_wr_data, trap_valid, trap_cause, trap_pc, flush_out, and instret to 0.
REQ-038 Reset asserted mid-trap SHALL abandon the trap; after release, the block SHALL accept on the first rising edge with valid input.

Verification
REQ-039 Retire rd=5, result=0xDEADBEEF at edge N -> rf_wr_enable=1, addr=5, data=0xDEADBEEF in cycle N+1 only; instret 0->1.
REQ-040 Retire rd=0, then NOP, valid=1 -> no rf_wr_enable; instret +1 for rd=0 only.
REQ-041 Exception cause=2, PC=0x100 -> flush_out pulses for 1 cycle; trap_valid=1, cause=2, pc=0x100 held; stall_out=1; inputs ignored; trap_ack after 3 cycles -> RUN next cycle, stall_out=0.
REQ-042 trap_ack held high during TRAP_FLUSH -> state still passes through TRAP_WAIT; exit on the following edge.
REQ-043 Preload instret to 2^64-1 via 2^64-1 retires (forced) -> next retire -> instret=0.
REQ-044 Assert reset asynchronously mid-TRAP_WAIT, between clk edges -> all outputs 0 immediately; first valid instruction after release retires normally.

Source files
------------

// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
//
// Last pipeline stage. It retires instructions from the memory stage into the
// register file, counts retired instructions, and turns an excepting
// instruction into a trap. A trap takes a one-cycle flush, then waits for the
// trap handler's acknowledge.
//
// Handshake: pipeline_in_valid has no ready partner. An instruction is taken
// ("accept") on any rising edge where the FSM is in RUN and
// pipeline_in_valid=1. Outside RUN, stall_out=1 tells upstream stages that
// nothing is being taken, and inputs are ignored.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   pipeline_in_valid   memory stage presents an instruction
//   nop_instr_in        instruction is a NOP (no write, no count)
//   result_in           write-back value
//   rd_addr_in          destination register (x0 is never written)
//   PC_in               PC of the instruction
//   exception_in        exception cause
//   exception_in_valid  instruction raised an exception
//   trap_ack            trap handler consumed the trap (used in TRAP_WAIT only)
//   rf_wr_enable        register-file write strobe, one cycle per write
//   rf_wr_addr          register-file write address (held between writes)
//   rf_wr_data          register-file write data (held between writes)
//   trap_valid          a trap is pending
//   trap_cause          latched exception cause
//   trap_pc             latched faulting PC
//   flush_out           one-cycle pipeline flush request
//   stall_out           stall request, high whenever the FSM is not in RUN
//   instret             64-bit retired-instruction counter (wraps)
//   fsm_state           debug view of the FSM state (0 RUN, 1 FLUSH, 2 WAIT)
// -----------------------------------------------------------------------------
module writeback #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int EXC_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipeline_in_valid,
   input  logic              nop_instr_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic [4:0]        rd_addr_in,
   input  logic [ADDR_W-1:0] PC_in,
   input  logic [EXC_W-1:0]  exception_in,
   input  logic              exception_in_valid,
   input  logic              trap_ack,
   output logic              rf_wr_enable,
   output logic [4:0]        rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              trap_valid,
   output logic [EXC_W-1:0]  trap_cause,
   output logic [ADDR_W-1:0] trap_pc,
   output logic              flush_out,
   output logic              stall_out,
   output logic [63:0]       instret,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      TRAP_FLUSH = 2'd1,
      TRAP_WAIT  = 2'd2
   } state_t;

   state_t state, next_state;

   logic accept;
   logic retire;
   logic take_trap;
   logic trap_release;
   logic do_write;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and per-edge decisions
   // -------------------------------------------------------------------------
   always_comb begin
      next_state   = state;
      accept       = 1'b0;
      retire       = 1'b0;
      take_trap    = 1'b0;
      trap_release = 1'b0;
      do_write     = 1'b0;

      unique case (state)
         RUN: begin
            accept = pipeline_in_valid;
            // The exception wins over the NOP flag: an excepting NOP still traps.
            take_trap = accept && exception_in_valid;
            retire    = accept && !exception_in_valid && !nop_instr_in;
            do_write  = retire && (rd_addr_in != 5'd0);
            if (take_trap) begin
               next_state = TRAP_FLUSH;
            end
         end
         TRAP_FLUSH: begin
            // trap_ack is deliberately not looked at here; the flush cycle
            // always happens and is always followed by TRAP_WAIT.
            next_state = TRAP_WAIT;
         end
         TRAP_WAIT: begin
            trap_release = trap_ack;
            if (trap_ack) begin
               next_state = RUN;
            end
         end
         default: begin
            next_state = RUN;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: register-file write port, retire counter, trap latch
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_wr_enable <= 1'b0;
         rf_wr_addr   <= '0;
         rf_wr_data   <= '0;
         instret      <= '0;
         trap_valid   <= 1'b0;
         trap_cause   <= '0;
         trap_pc      <= '0;
      end else begin
         rf_wr_enable <= do_write;
         // Address/data only move on a real write, so they hold otherwise.
         if (do_write) begin
            rf_wr_addr <= rd_addr_in;
            rf_wr_data <= result_in;
         end
         // Writes to x0 still retire and are counted.
         if (retire) begin
            instret <= instret + 64'd1;
         end
         if (take_trap) begin
            trap_valid <= 1'b1;
            trap_cause <= exception_in;
            trap_pc    <= PC_in;
         end else if (trap_release) begin
            trap_valid <= 1'b0;
         end
      end
   end

   // The flush request is exactly the TRAP_FLUSH cycle; decoding it from the
   // state keeps it at one cycle and lets reset clear it with the state.
   assign flush_out = (state == TRAP_FLUSH);
   assign stall_out = (state != RUN);
   assign fsm_state = state;

endmodule

// File: tb/tb_writeback.sv
// -----------------------------------------------------------------------------
// tb_writeback
//
// Directed test of writeback with hand-computed expectations. Inputs are
// driven 1 time unit after a rising edge; outputs are sampled 1 time unit
// after the following rising edge.
// -----------------------------------------------------------------------------
module tb_writeback;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int EXC_W  = 4;

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_FLUSH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- DUT
   logic              pipeline_in_valid;
   logic              nop_instr_in;
   logic [DATA_W-1:0] result_in;
   logic [4:0]        rd_addr_in;
   logic [ADDR_W-1:0] PC_in;
   logic [EXC_W-1:0]  exception_in;
   logic              exception_in_valid;
   logic              trap_ack;
   logic              rf_wr_enable;
   logic [4:0]        rf_wr_addr;
   logic [DATA_W-1:0] rf_wr_data;
   logic              trap_valid;
   logic [EXC_W-1:0]  trap_cause;
   logic [ADDR_W-1:0] trap_pc;
   logic              flush_out;
   logic              stall_out;
   logic [63:0]       instret;
   logic [1:0]        fsm_state;

   writeback #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .EXC_W (EXC_W)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .pipeline_in_valid (pipeline_in_valid),
      .nop_instr_in      (nop_instr_in),
      .result_in         (result_in),
      .rd_addr_in        (rd_addr_in),
      .PC_in             (PC_in),
      .exception_in      (exception_in),
      .exception_in_valid(exception_in_valid),
      .trap_ack          (trap_ack),
      .rf_wr_enable      (rf_wr_enable),
      .rf_wr_addr        (rf_wr_addr),
      .rf_wr_data        (rf_wr_data),
      .trap_valid        (trap_valid),
      .trap_cause        (trap_cause),
      .trap_pc           (trap_pc),
      .flush_out         (flush_out),
      .stall_out         (stall_out),
      .instret           (instret),
      .fsm_state         (fsm_state)
   );

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      pipeline_in_valid  = 1'b0;
      nop_instr_in       = 1'b0;
      result_in          = '0;
      rd_addr_in         = '0;
      PC_in              = '0;
      exception_in       = '0;
      exception_in_valid = 1'b0;
   endtask

   task automatic drive_instr(input logic nop, input logic [4:0] rd,
                              input logic [DATA_W-1:0] res,
                              input logic [ADDR_W-1:0] pc);
      pipeline_in_valid  = 1'b1;
      nop_instr_in       = nop;
      rd_addr_in         = rd;
      result_in          = res;
      PC_in              = pc;
      exception_in       = '0;
      exception_in_valid = 1'b0;
   endtask

   task automatic drive_exc(input logic nop, input logic [4:0] rd,
                            input logic [EXC_W-1:0] cause,
                            input logic [ADDR_W-1:0] pc);
      pipeline_in_valid  = 1'b1;
      nop_instr_in       = nop;
      rd_addr_in         = rd;
      result_in          = 32'hBAD0_0000;
      PC_in              = pc;
      exception_in       = cause;
      exception_in_valid = 1'b1;
   endtask

   // Write-strobe check: enable plus address/data, with a shared tag.
   task automatic check_wr(input string tag, input logic en,
                           input logic [4:0] addr, input logic [DATA_W-1:0] data);
      check({tag, ".en"},   64'(rf_wr_enable), 64'(en));
      check({tag, ".addr"}, 64'(rf_wr_addr),   64'(addr));
      check({tag, ".data"}, 64'(rf_wr_data),   64'(data));
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      reset    = 1'b1;
      trap_ack = 1'b0;
      drive_idle();

      // Reset state
      tick();
      check("rst.state", 64'(fsm_state), 64'(S_RUN));
      check_wr("rst", 1'b0, 5'd0, 32'd0);
      check("rst.instret", instret, 64'd0);
      check("rst.trap_valid", 64'(trap_valid), 64'd0);
      check("rst.flush", 64'(flush_out), 64'd0);
      check("rst.stall", 64'(stall_out), 64'd0);
      reset = 1'b0;
      tick();

      // Single retire, rd=5: write in the next cycle only, instret 0 -> 1
      drive_instr(1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0000_0010);
      tick();
      check_wr("ret5", 1'b1, 5'd5, 32'hDEAD_BEEF);
      check("ret5.instret", instret, 64'd1);
      drive_idle();
      tick();
      check_wr("ret5.hold", 1'b0, 5'd5, 32'hDEAD_BEEF);

      // rd=0 retires (counted, no write); NOP neither writes nor counts
      drive_instr(1'b0, 5'd0, 32'h0000_1234, 32'h0000_0014);
      tick();
      check_wr("rd0", 1'b0, 5'd5, 32'hDEAD_BEEF);
      check("rd0.instret", instret, 64'd2);
      drive_instr(1'b1, 5'd7, 32'h0000_7777, 32'h0000_0018);
      tick();
      check_wr("nop", 1'b0, 5'd5, 32'hDEAD_BEEF);
      check("nop.instret", instret, 64'd2);

      // Back-to-back retires: two consecutive write pulses, no bubble
      drive_instr(1'b0, 5'd1, 32'hAAAA_0001, 32'h0000_001C);
      tick();
      check_wr("b2b.0", 1'b1, 5'd1, 32'hAAAA_0001);
      drive_instr(1'b0, 5'd2, 32'hBBBB_0002, 32'h0000_0020);
      tick();
      check_wr("b2b.1", 1'b1, 5'd2, 32'hBBBB_0002);
      check("b2b.instret", instret, 64'd4);
      drive_idle();
      tick();
      check("b2b.end_en", 64'(rf_wr_enable), 64'd0);

      // Exception cause=2 PC=0x100, NOP flag also set: exception wins
      drive_exc(1'b1, 5'd3, 4'd2, 32'h0000_0100);
      tick();
      check("exc.state", 64'(fsm_state), 64'(S_FLUSH));
      check("exc.flush", 64'(flush_out), 64'd1);
      check("exc.stall", 64'(stall_out), 64'd1);
      check("exc.trap_valid", 64'(trap_valid), 64'd1);
      check("exc.cause", 64'(trap_cause), 64'd2);
      check("exc.pc", 64'(trap_pc), 64'h100);
      check("exc.en", 64'(rf_wr_enable), 64'd0);
      check("exc.instret", instret, 64'd4);
      // Inputs present during the trap must be ignored, including a new exception
      drive_exc(1'b0, 5'd9, 4'd5, 32'h0000_0200);
      tick();
      check("exc.wait_state", 64'(fsm_state), 64'(S_WAIT));
      check("exc.flush_once", 64'(flush_out), 64'd0);
      check("exc.wait_stall", 64'(stall_out), 64'd1);
      drive_instr(1'b0, 5'd9, 32'h9999_9999, 32'h0000_0204);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("exc.hold_cause", 64'(trap_cause), 64'd2);
         check("exc.hold_pc", 64'(trap_pc), 64'h100);
         check("exc.hold_valid", 64'(trap_valid), 64'd1);
         check("exc.ign_en", 64'(rf_wr_enable), 64'd0);
         check("exc.ign_instret", instret, 64'd4);
      end
      drive_idle();
      trap_ack = 1'b1;
      tick();
      check("ack.state", 64'(fsm_state), 64'(S_RUN));
      check("ack.trap_valid", 64'(trap_valid), 64'd0);
      check("ack.stall", 64'(stall_out), 64'd0);
      trap_ack = 1'b0;

      // trap_ack held through TRAP_FLUSH: still visits TRAP_WAIT, exits next edge
      drive_exc(1'b0, 5'd4, 4'd7, 32'h0000_0300);
      trap_ack = 1'b1;
      tick();
      check("ackf.state0", 64'(fsm_state), 64'(S_FLUSH));
      check("ackf.cause", 64'(trap_cause), 64'd7);
      drive_idle();
      tick();
      check("ackf.state1", 64'(fsm_state), 64'(S_WAIT));
      check("ackf.valid1", 64'(trap_valid), 64'd1);
      tick();
      check("ackf.state2", 64'(fsm_state), 64'(S_RUN));
      check("ackf.valid2", 64'(trap_valid), 64'd0);
      trap_ack = 1'b0;

      // Asynchronous reset between edges while in TRAP_WAIT
      drive_exc(1'b0, 5'd4, 4'd3, 32'h0000_0400);
      tick();
      drive_idle();
      tick();
      check("arst.pre_state", 64'(fsm_state), 64'(S_WAIT));
      #2 reset = 1'b1;
      #1;
      check("arst.state", 64'(fsm_state), 64'(S_RUN));
      check("arst.trap_valid", 64'(trap_valid), 64'd0);
      check("arst.cause", 64'(trap_cause), 64'd0);
      check("arst.pc", 64'(trap_pc), 64'd0);
      check("arst.stall", 64'(stall_out), 64'd0);
      check("arst.flush", 64'(flush_out), 64'd0);
      check("arst.instret", instret, 64'd0);
      check_wr("arst", 1'b0, 5'd0, 32'd0);
      #1 reset = 1'b0;
      drive_instr(1'b0, 5'd4, 32'h0000_0055, 32'h0000_0500);
      tick();
      check_wr("post_rst", 1'b1, 5'd4, 32'h0000_0055);
      check("post_rst.instret", instret, 64'd1);

      // instret wrap: preload all-ones, one retire wraps to zero
      drive_idle();
      force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      release dut.instret;
      check("wrap.preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      drive_instr(1'b0, 5'd6, 32'h0000_0066, 32'h0000_0600);
      tick();
      check("wrap.instret", instret, 64'd0);
      check_wr("wrap", 1'b1, 5'd6, 32'h0000_0066);
      drive_idle();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish by t=20000");
      $fatal(1);
   end

endmodule
